// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller: drives the PC select/strobe, issues one
// outstanding instruction-memory request at a time, holds the fetched word for decode.
//
// state | meaning
// IDLE  | first cycle after reset, nothing issued
// ISSUE | latch PC as fetch address, or enter HALT if requested
// REQ   | request presented, waiting for memory to accept
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction presented to decode until consumed
// HALT  | sticky stop, left only by reset
module fetch_sequencer #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    pc_in,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    input  logic             br_taken,
    input  logic             jmp_taken,
    input  logic             halt,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [DW-1:0]    imem_rsp_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [DW-1:0]    instr_out,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t           state, state_nx;
    logic             stale, stale_nx;
    logic             halt_pend;
    logic             instr_valid_nx;
    logic [AW-1:0]    addr_nx;
    logic [DW-1:0]    instr_nx;
    logic [CNT_W-1:0] count_nx;
    logic             redirect;
    logic             live;

    assign redirect = br_taken | jmp_taken;
    assign live     = (state != S_IDLE) && (state != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stale       <= 1'b0;
            halt_pend   <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nx;
            stale       <= stale_nx;
            halt_pend   <= halt_pend | halt;
            imem_addr   <= addr_nx;
            instr_out   <= instr_nx;
            instr_valid <= instr_valid_nx;
            fetch_count <= count_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        stale_nx       = stale;
        addr_nx        = imem_addr;
        instr_nx       = instr_out;
        instr_valid_nx = instr_valid;
        count_nx       = fetch_count;
        pc_en          = 1'b0;
        pc_sel         = 2'b00;
        imem_req_valid = 1'b0;
        halted         = 1'b0;

        // Redirects always win the PC, jump over branch.
        if (redirect && live) begin
            pc_en  = 1'b1;
            pc_sel = jmp_taken ? 2'b10 : 2'b01;
        end

        case (state)
            S_IDLE: state_nx = S_ISSUE;
            S_ISSUE: begin
                if (halt_pend) begin
                    state_nx = S_HALT;
                end else if (!redirect) begin
                    addr_nx  = pc_in;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (redirect) stale_nx = 1'b1;
                if (imem_req_ready) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    stale_nx = 1'b0;
                    if (!stale && !redirect) begin
                        instr_nx       = imem_rsp_data;
                        instr_valid_nx = 1'b1;
                        pc_en          = 1'b1;
                        pc_sel         = 2'b00;
                        state_nx       = S_HOLD;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end else if (redirect) begin
                    stale_nx = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect kills the held instruction even if decode takes it.
                if (redirect) begin
                    instr_valid_nx = 1'b0;
                    state_nx       = S_ISSUE;
                end else if (instr_ready) begin
                    count_nx       = fetch_count + 1'b1;
                    instr_valid_nx = 1'b0;
                    state_nx       = S_ISSUE;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC and memory models, table-driven fetches,
// scripted redirect/halt/reset sequences, scoreboard of expected instructions.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        br_taken, jmp_taken, halt;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [15:0] instr_out;
    logic        halted;
    logic [15:0] fetch_count;

    fetch_sequencer #(.AW(16), .DW(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_en(pc_en), .pc_sel(pc_sel),
        .br_taken(br_taken), .jmp_taken(jmp_taken), .halt(halt),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_out(instr_out), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h0101) ^ 16'h5A3C;
    endfunction

    // PC register model
    logic [15:0] pc, pc_rst, imm, alu_out;
    assign pc_in = pc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= pc_rst;
        else if (pc_en) begin
            case (pc_sel)
                2'b00: pc <= pc + 16'd1;
                2'b01: pc <= pc + 16'd1 + imm;
                2'b10: pc <= alu_out;
                default: pc <= pc;
            endcase
        end
    end

    // Instruction memory model: fixed latency, one response per accepted request
    logic        mem_ready, force_rsp, pend;
    int          mem_lat, cnt;
    logic [15:0] paddr;
    assign imem_req_ready = mem_ready;
    assign imem_rsp_valid = (pend && cnt == 0) || force_rsp;
    assign imem_rsp_data  = mem_word(paddr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0; cnt <= 0; paddr <= 16'h0;
        end else if (imem_req_valid && mem_ready) begin
            pend <= 1'b1; cnt <= mem_lat - 1; paddr <= imem_addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    // Scoreboard: every rising instr_valid must match the next expected word
    logic iv_prev = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst_n && instr_valid && !iv_prev) begin
            if (exp_q.size() == 0) chk("unexpected_instr_valid", instr_valid, 1'b0);
            else chk("instr_out", instr_out, exp_q.pop_front());
        end
        iv_prev = instr_valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] addr;
        int          stall;
        logic [15:0] count;
    } vec_t;
    vec_t vecs[4];

    task automatic check_reset_outputs();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_count", fetch_count, 0);
    endtask

    task automatic wait_req(input logic [15:0] ea);
        int n = 0;
        while (!imem_req_valid && n < 30) begin @(negedge clk); #1; n++; end
        chk("req_seen", imem_req_valid, 1);
        chk("fetch_addr", imem_addr, ea);
    endtask

    task automatic get_to_hold(input logic [15:0] ea);
        int n = 0;
        int pcs = 0;
        wait_req(ea);
        exp_q.push_back(mem_word(ea));
        while (!instr_valid && n < 30) begin
            if (pc_en) begin pcs++; chk("seq_pc_sel", pc_sel, 2'b00); end
            @(negedge clk); #1; n++;
        end
        chk("instr_valid_seen", instr_valid, 1);
        chk("seq_pc_en_pulses", pcs, 1);
    endtask

    task automatic finish_hold(input int stall, input logic [15:0] ecnt);
        logic [15:0] held;
        held = instr_out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); instr_ready = 1'b0; #1;
            chk("stall_instr_out", instr_out, held);
            chk("stall_no_req", imem_req_valid, 0);
            chk("stall_no_pc_en", pc_en, 0);
        end
        @(negedge clk); instr_ready = 1'b1; #1;
        chk("hold_valid", instr_valid, 1);
        @(negedge clk); instr_ready = 1'b0; #1;
        chk("consume_count", fetch_count, ecnt);
        chk("consume_drop_valid", instr_valid, 0);
    endtask

    task automatic do_fetch(input logic [15:0] ea, input int stall, input logic [15:0] ecnt);
        get_to_hold(ea);
        finish_hold(stall, ecnt);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 0, 16'd1};
        vecs[1] = '{16'h0001, 0, 16'd2};
        vecs[2] = '{16'h0002, 5, 16'd3};
        vecs[3] = '{16'h0003, 1, 16'd4};

        rst_n = 1'b0; br_taken = 0; jmp_taken = 0; halt = 0; instr_ready = 0;
        mem_ready = 1; force_rsp = 0; mem_lat = 1; imm = 0; alu_out = 0; pc_rst = 0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs();

        // First request only after the second edge following release
        @(negedge clk); rst_n = 1'b1; #1;
        chk("idle_no_req", imem_req_valid, 0);
        @(negedge clk); #1;
        chk("issue_no_req", imem_req_valid, 0);
        @(negedge clk); #1;
        chk("first_req", imem_req_valid, 1);

        for (int i = 0; i < 4; i++) do_fetch(vecs[i].addr, vecs[i].stall, vecs[i].count);

        // Branch while decode consumes: no count, new target fetched
        get_to_hold(16'h0004);
        @(negedge clk); imm = 16'h0010; br_taken = 1; instr_ready = 1; #1;
        chk("hold_br_pc_en", pc_en, 1);
        chk("hold_br_pc_sel", pc_sel, 2'b01);
        @(negedge clk); br_taken = 0; instr_ready = 0; #1;
        chk("hold_br_valid_drop", instr_valid, 0);
        chk("hold_br_count", fetch_count, 16'd4);
        mem_lat = 3;
        wait_req(16'h0016);

        // Jump+branch in WAIT, response arrives later and must be dropped
        @(negedge clk); alu_out = 16'h0100; br_taken = 1; jmp_taken = 1; #1;
        chk("wait_jmp_pc_en", pc_en, 1);
        chk("wait_jmp_pc_sel", pc_sel, 2'b10);
        @(negedge clk); br_taken = 0; jmp_taken = 0; #1;
        chk("wait_quiet_pc_en", pc_en, 0);
        @(negedge clk); #1;
        chk("stale_rsp_seen", imem_rsp_valid, 1);
        chk("stale_rsp_no_pc_en", pc_en, 0);
        @(negedge clk); #1;
        chk("stale_no_valid", instr_valid, 0);
        mem_lat = 1;
        do_fetch(16'h0100, 0, 16'd5);

        // Redirect coincident with the response
        wait_req(16'h0101);
        @(negedge clk); imm = 16'h0020; br_taken = 1; #1;
        chk("coinc_rsp_seen", imem_rsp_valid, 1);
        chk("coinc_pc_en", pc_en, 1);
        chk("coinc_pc_sel", pc_sel, 2'b01);
        @(negedge clk); br_taken = 0; #1;
        chk("coinc_no_pc_en", pc_en, 0);
        chk("coinc_no_valid", instr_valid, 0);
        do_fetch(16'h0122, 0, 16'd6);

        // Halt requested in HOLD, taken from ISSUE after the consume
        get_to_hold(16'h0123);
        @(negedge clk); halt = 1; #1;
        chk("halt_pending_not_halted", halted, 0);
        @(negedge clk); halt = 0; instr_ready = 1; #1;
        @(negedge clk); instr_ready = 0; #1;
        chk("halt_consume_count", fetch_count, 16'd7);
        chk("halt_issue_not_halted", halted, 0);
        @(negedge clk); br_taken = 1; #1;
        chk("halted", halted, 1);
        chk("halt_br_ignored", pc_en, 0);
        chk("halt_no_valid", instr_valid, 0);
        @(negedge clk); br_taken = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("halt_no_req", imem_req_valid, 0);
            chk("halt_sticky", halted, 1);
        end

        // Reset mid-WAIT aborts everything immediately
        @(negedge clk); rst_n = 0; pc_rst = 16'h0040; #1;
        chk("rst_clears_halted", halted, 0);
        @(negedge clk); rst_n = 1; mem_lat = 3;
        wait_req(16'h0040);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 0; #1;
        check_reset_outputs();

        // Stray response after release without a request is ignored
        @(negedge clk); rst_n = 1; mem_ready = 0; force_rsp = 1; mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stray_no_valid", instr_valid, 0);
            chk("stray_no_pc_en", pc_en, 0);
            @(negedge clk);
        end
        force_rsp = 0; mem_ready = 1;
        do_fetch(16'h0040, 2, 16'd1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
